// File: rtl/aes_round_sched.sv
// AES core top-level sequencer: key-expansion start/wait, per-block round
// stepping with first/last strobes, and a valid/ready result handshake.
module aes_round_sched #(
   parameter int unsigned KEXP_OVH = 3,
   parameter int unsigned AW       = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_load,
   input  logic [3:0]    nk_in,
   output logic          k_ready,
   output logic [3:0]    Nk,
   output logic [AW-1:0] Addr,
   input  logic          blk_valid,
   output logic          blk_ready,
   output logic          rnd_en,
   output logic          rnd_first,
   output logic          rnd_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          key_valid,
   output logic          busy,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE, S_KSTART, S_KWAIT, S_READY, S_ROUND, S_OUT
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    nk_r;
   logic [AW-1:0] nr_r;
   logic [AW-1:0] addr_r;
   logic [4:0]    cnt_r;
   logic          key_valid_r;
   logic          err_r;

   logic          nk_legal;
   logic [AW-1:0] nr_dec;
   logic          key_window;
   logic          key_req;
   logic          key_bad;

   always_comb begin
      nk_legal = 1'b1;
      nr_dec   = '0;
      case (nk_in)
         4'd3:    nr_dec = AW'(10);
         4'd5:    nr_dec = AW'(12);
         4'd7:    nr_dec = AW'(14);
         default: nk_legal = 1'b0;
      endcase
   end

   // A block offered in READY takes priority over a simultaneous key_load.
   assign key_window = (state == S_IDLE) || ((state == S_READY) && !blk_valid);
   assign key_req    = key_load && key_window && nk_legal;
   assign key_bad    = key_load && key_window && !nk_legal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (key_req) state_nxt = S_KSTART;
         S_KSTART: state_nxt = S_KWAIT;
         S_KWAIT:  if (cnt_r == 5'd1) state_nxt = S_READY;
         S_READY: begin
            if (blk_valid)    state_nxt = S_ROUND;
            else if (key_req) state_nxt = S_KSTART;
         end
         S_ROUND:  if (addr_r == nr_r) state_nxt = S_OUT;
         S_OUT:    if (out_ready) state_nxt = S_READY;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nk_r        <= '0;
         nr_r        <= '0;
         addr_r      <= '0;
         cnt_r       <= '0;
         key_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         err_r <= key_bad;
         if (key_req) begin
            nk_r        <= nk_in;
            nr_r        <= nr_dec;
            key_valid_r <= 1'b0;
         end
         case (state)
            // Loaded one below the full latency: the KSTART cycle counts too.
            S_KSTART: cnt_r <= 5'(nr_r) + 5'(KEXP_OVH) - 5'd1;
            S_KWAIT: begin
               cnt_r <= cnt_r - 5'd1;
               if (cnt_r == 5'd1) key_valid_r <= 1'b1;
            end
            S_READY: if (blk_valid) addr_r <= '0;
            S_ROUND: if (addr_r != nr_r) addr_r <= addr_r + AW'(1);
            default: ;
         endcase
      end
   end

   assign k_ready   = (state == S_KSTART);
   assign Nk        = nk_r;
   assign Addr      = addr_r;
   assign blk_ready = (state == S_READY);
   assign rnd_en    = (state == S_ROUND);
   assign rnd_first = (state == S_ROUND) && (addr_r == '0);
   assign rnd_last  = (state == S_ROUND) && (addr_r == nr_r);
   assign out_valid = (state == S_OUT);
   assign key_valid = key_valid_r;
   assign busy      = (state == S_KSTART) || (state == S_KWAIT) ||
                      (state == S_ROUND)  || (state == S_OUT);
   assign err       = err_r;

endmodule

// File: tb/tb_aes_round_sched.sv
// Scoreboard bench for aes_round_sched: expected round sequences are queued
// at block acceptance and compared cycle by cycle as the DUT steps.
module tb_aes_round_sched;

   localparam int KO = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_load;
   logic [3:0] nk_in;
   logic       k_ready;
   logic [3:0] Nk;
   logic [3:0] Addr;
   logic       blk_valid;
   logic       blk_ready;
   logic       rnd_en;
   logic       rnd_first;
   logic       rnd_last;
   logic       out_valid;
   logic       out_ready;
   logic       key_valid;
   logic       busy;
   logic       err;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   typedef struct {
      logic [3:0] addr;
      logic       first;
      logic       last;
   } rnd_t;
   rnd_t sb[$];

   always #5 clk = ~clk;

   aes_round_sched #(.KEXP_OVH(KO), .AW(4)) dut (
      .clk(clk), .rst(rst), .key_load(key_load), .nk_in(nk_in),
      .k_ready(k_ready), .Nk(Nk), .Addr(Addr), .blk_valid(blk_valid),
      .blk_ready(blk_ready), .rnd_en(rnd_en), .rnd_first(rnd_first),
      .rnd_last(rnd_last), .out_valid(out_valid), .out_ready(out_ready),
      .key_valid(key_valid), .busy(busy), .err(err)
   );

   function automatic int nr_of(input int nk);
      case (nk)
         3: return 10;
         5: return 12;
         7: return 14;
         default: return 0;
      endcase
   endfunction

   task automatic push_block(input int nr);
      rnd_t e;
      for (int a = 0; a <= nr; a++) begin
         e.addr  = 4'(a);
         e.first = (a == 0);
         e.last  = (a == nr);
         sb.push_back(e);
      end
   endtask

   // Drives a legal key_load and waits out the fixed expansion latency.
   task automatic load_key(input logic [3:0] nk);
      @(negedge clk);
      key_load = 1'b1;
      nk_in    = nk;
      @(negedge clk);
      key_load = 1'b0;
      repeat (nr_of(int'(nk)) + KO) @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({k_ready, Nk, Addr, blk_ready, rnd_en, rnd_first, rnd_last, out_valid, key_valid, busy, err} !== 17'd0)
         $display("FAIL reset_hold: outputs=%b expected all 0",
                  {k_ready, Nk, Addr, blk_ready, rnd_en, rnd_first, rnd_last, out_valid, key_valid, busy, err});
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({k_ready, blk_ready, busy, key_valid} !== 4'd0)
         $display("FAIL reset_release: k_ready/blk_ready/busy/key_valid=%b expected 0000",
                  {k_ready, blk_ready, busy, key_valid});
      else pass_cnt++;
   endtask

   task automatic test_illegal_idle;
      key_load = 1'b1;
      nk_in    = 4'd4;
      @(negedge clk);
      key_load = 1'b0;
      total_cnt++;
      if ({err, k_ready, busy, Nk} !== {1'b1, 1'b0, 1'b0, 4'd0})
         $display("FAIL illegal_idle_err: err/k_ready/busy/Nk=%b expected 1000000",
                  {err, k_ready, busy, Nk});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({err, k_ready, busy} !== 3'b000)
         $display("FAIL illegal_idle_after: err/k_ready/busy=%b expected 000", {err, k_ready, busy});
      else pass_cnt++;
   endtask

   task automatic test_key128;
      key_load = 1'b1;
      nk_in    = 4'd3;
      @(negedge clk);
      key_load = 1'b0;
      total_cnt++;
      if ({k_ready, busy, key_valid, Nk} !== {1'b1, 1'b1, 1'b0, 4'd3})
         $display("FAIL key128_start: k_ready/busy/key_valid/Nk=%b expected 1100011",
                  {k_ready, busy, key_valid, Nk});
      else pass_cnt++;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({k_ready, key_valid, blk_ready} !== {1'b0, c == 13, c == 13})
            $display("FAIL key128_wait[%0d]: k_ready/key_valid/blk_ready=%b expected %b",
                     c, {k_ready, key_valid, blk_ready}, {1'b0, c == 13, c == 13});
         else pass_cnt++;
      end
   endtask

   task automatic test_block128;
      rnd_t e;
      blk_valid = 1'b1;
      push_block(10);
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         if (i == 0) blk_valid = 1'b0;
         e = sb.pop_front();
         total_cnt++;
         if ({rnd_en, Addr, rnd_first, rnd_last, out_valid, blk_ready} !== {1'b1, e.addr, e.first, e.last, 2'b00})
            $display("FAIL block128_round[%0d]: en/addr/first/last/ov/br=%b expected %b", i,
                     {rnd_en, Addr, rnd_first, rnd_last, out_valid, blk_ready},
                     {1'b1, e.addr, e.first, e.last, 2'b00});
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++;
      if ({out_valid, rnd_en, busy, Addr} !== {3'b101, 4'd10})
         $display("FAIL block128_out: ov/en/busy/addr=%b expected 1011010", {out_valid, rnd_en, busy, Addr});
      else pass_cnt++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total_cnt++;
      if ({blk_ready, out_valid, key_valid} !== 3'b101)
         $display("FAIL block128_back_ready: br/ov/kv=%b expected 101", {blk_ready, out_valid, key_valid});
      else pass_cnt++;
   endtask

   task automatic test_aes256_backpressure;
      rnd_t e;
      load_key(4'd7);
      blk_valid = 1'b1;
      push_block(14);
      for (int i = 0; i <= 14; i++) begin
         @(negedge clk);
         if (i == 0) blk_valid = 1'b0;
         if (i == 3) begin key_load = 1'b1; nk_in = 4'd3; end
         if (i == 4) key_load = 1'b0;
         e = sb.pop_front();
         total_cnt++;
         if ({rnd_en, Addr, rnd_first, rnd_last, k_ready, Nk} !== {1'b1, e.addr, e.first, e.last, 1'b0, 4'd7})
            $display("FAIL aes256_round[%0d]: en/addr/first/last/kr/nk=%b expected %b", i,
                     {rnd_en, Addr, rnd_first, rnd_last, k_ready, Nk},
                     {1'b1, e.addr, e.first, e.last, 1'b0, 4'd7});
         else pass_cnt++;
      end
      for (int h = 0; h < 5; h++) begin
         @(negedge clk);
         total_cnt++;
         if ({out_valid, Addr, blk_ready, rnd_en} !== {1'b1, 4'd14, 2'b00})
            $display("FAIL aes256_hold[%0d]: ov/addr/br/en=%b expected 1111000", h,
                     {out_valid, Addr, blk_ready, rnd_en});
         else pass_cnt++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total_cnt++;
      if ({blk_ready, out_valid} !== 2'b10)
         $display("FAIL aes256_release: br/ov=%b expected 10", {blk_ready, out_valid});
      else pass_cnt++;
   endtask

   task automatic test_back_to_back;
      rnd_t e;
      load_key(4'd5);
      for (int b = 0; b < 2; b++) begin
         total_cnt++;
         if ({blk_ready, key_valid} !== 2'b11)
            $display("FAIL b2b_ready[%0d]: br/kv=%b expected 11", b, {blk_ready, key_valid});
         else pass_cnt++;
         blk_valid = 1'b1;
         if (b == 1) begin key_load = 1'b1; nk_in = 4'd7; end
         push_block(12);
         for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i == 0) begin blk_valid = 1'b0; key_load = 1'b0; end
            e = sb.pop_front();
            total_cnt++;
            if ({rnd_en, Addr, rnd_first, rnd_last, k_ready, Nk, key_valid} !== {1'b1, e.addr, e.first, e.last, 1'b0, 4'd5, 1'b1})
               $display("FAIL b2b_round[%0d.%0d]: en/addr/first/last/kr/nk/kv=%b expected %b", b, i,
                        {rnd_en, Addr, rnd_first, rnd_last, k_ready, Nk, key_valid},
                        {1'b1, e.addr, e.first, e.last, 1'b0, 4'd5, 1'b1});
            else pass_cnt++;
         end
         @(negedge clk);
         total_cnt++;
         if ({out_valid, k_ready} !== 2'b10)
            $display("FAIL b2b_out[%0d]: ov/kr=%b expected 10", b, {out_valid, k_ready});
         else pass_cnt++;
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_illegal_ready;
      key_load = 1'b1;
      nk_in    = 4'd4;
      @(negedge clk);
      key_load = 1'b0;
      total_cnt++;
      if ({err, key_valid, blk_ready, k_ready, Nk} !== {3'b111, 1'b0, 4'd5})
         $display("FAIL illegal_ready_err: err/kv/br/kr/nk=%b expected 11100101",
                  {err, key_valid, blk_ready, k_ready, Nk});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({err, key_valid, k_ready} !== 3'b010)
         $display("FAIL illegal_ready_after: err/kv/kr=%b expected 010", {err, key_valid, k_ready});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      rnd_t e;
      blk_valid = 1'b1;
      push_block(12);
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i == 0) blk_valid = 1'b0;
         e = sb.pop_front();
         total_cnt++;
         if ({rnd_en, Addr} !== {1'b1, e.addr})
            $display("FAIL mid_round[%0d]: en/addr=%b expected %b", i, {rnd_en, Addr}, {1'b1, e.addr});
         else pass_cnt++;
      end
      rst = 1'b1;
      #1;
      sb.delete();
      total_cnt++;
      if ({k_ready, Nk, Addr, blk_ready, rnd_en, rnd_first, rnd_last, out_valid, key_valid, busy, err} !== 17'd0)
         $display("FAIL mid_reset_outputs: outputs=%b expected all 0",
                  {k_ready, Nk, Addr, blk_ready, rnd_en, rnd_first, rnd_last, out_valid, key_valid, busy, err});
      else pass_cnt++;
      @(negedge clk);
      rst       = 1'b0;
      blk_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total_cnt++;
         if ({blk_ready, rnd_en, key_valid} !== 3'b000)
            $display("FAIL mid_no_accept[%0d]: br/en/kv=%b expected 000", c, {blk_ready, rnd_en, key_valid});
         else pass_cnt++;
      end
      blk_valid = 1'b0;
      load_key(4'd3);
      total_cnt++;
      if ({key_valid, blk_ready, Nk} !== {2'b11, 4'd3})
         $display("FAIL mid_rekey: kv/br/nk=%b expected 110011", {key_valid, blk_ready, Nk});
      else pass_cnt++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      key_load  = 1'b0;
      nk_in     = 4'd0;
      blk_valid = 1'b0;
      out_ready = 1'b0;
      test_reset;
      test_illegal_idle;
      test_key128;
      test_block128;
      test_aes256_backpressure;
      test_back_to_back;
      test_illegal_ready;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
